// File: rtl/sprite_bitmap_writer_pkg.sv
// rtl/sprite_bitmap_writer_pkg.sv - shared types and constants for the sprite bitmap writer
// Optional clear feature: SPRITE_WRITER_CLEAR_EN adds the CLEAR state to the enum.
package sprite_bitmap_writer_pkg;

   localparam int SPRITE_BITS = 5;
   localparam int ADDR_BITS   = 2 * SPRITE_BITS;

   typedef logic [7:0] colour_t;

   localparam colour_t DEFAULT_TRANSPARENT = 8'h1C;

`ifdef SPRITE_WRITER_CLEAR_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CLEAR = 2'd2
   } state_e;
`else
   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_e;
`endif

endpackage

// File: rtl/sprite_ram_32x32.sv
// rtl/sprite_ram_32x32.sv - 32x32x8 synchronous 1R1W read-first bitmap RAM
module sprite_ram_32x32
   import sprite_bitmap_writer_pkg::*;
(
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  colour_t              wdata_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output colour_t              rdata_o
);

   colour_t mem_q [0:(1<<ADDR_BITS)-1];
   colour_t rdata_q;

   // Write and registered read on the same edge; the read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_bitmap_writer.sv
// rtl/sprite_bitmap_writer.sv - streams a 32x32 RGB332 sprite into RAM and serves VGA reads
// Optional clear feature: define SPRITE_WRITER_CLEAR_EN to add clear_start and the CLEAR state.
module sprite_bitmap_writer
   import sprite_bitmap_writer_pkg::*;
#(
   parameter colour_t TRANSPARENT_ENCODING = DEFAULT_TRANSPARENT,
   parameter int      WORDS                = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
`ifdef SPRITE_WRITER_CLEAR_EN
   input  logic        clear_start,
`endif
   output logic        busy,
   output logic        done,
   input  logic [10:0] offset_x,
   input  logic [10:0] offset_y,
   input  logic        inside_rectangle,
   output logic        drawing_request,
   output logic [7:0]  rgb_out
);

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WORDS - 1);

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] waddr_q, waddr_d;
   logic                 done_q, done_d;
   logic                 inside_q;
   logic                 ram_we;
   colour_t              ram_wdata;
   colour_t              ram_rdata;
   logic [ADDR_BITS-1:0] raddr;
   logic                 unused_offset_bits;

   // Only the low five bits of each offset index the 32x32 bitmap.
   assign raddr              = {offset_y[SPRITE_BITS-1:0], offset_x[SPRITE_BITS-1:0]};
   assign unused_offset_bits = ^{offset_x[10:SPRITE_BITS], offset_y[10:SPRITE_BITS]};

   // Next-state, write-address and write-port control.
   always_comb begin
      state_d   = state_q;
      waddr_d   = waddr_q;
      done_d    = 1'b0;
      ram_we    = 1'b0;
      ram_wdata = s_data;
      s_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = LOAD;
               waddr_d = '0;
            end
`ifdef SPRITE_WRITER_CLEAR_EN
            else if (clear_start) begin
               state_d = CLEAR;
               waddr_d = '0;
            end
`endif
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               ram_we  = 1'b1;
               waddr_d = waddr_q + 1'b1;
               if (waddr_q == LAST_ADDR) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
`ifdef SPRITE_WRITER_CLEAR_EN
         CLEAR: begin
            ram_we    = 1'b1;
            ram_wdata = TRANSPARENT_ENCODING;
            waddr_d   = waddr_q + 1'b1;
            if (waddr_q == LAST_ADDR) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      // A reset abandons the operation without committing the beat on that edge.
      if (rst) begin
         ram_we = 1'b0;
      end
   end

   // State, address, done pulse and the read-side inside flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         waddr_q  <= '0;
         done_q   <= 1'b0;
         inside_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         waddr_q  <= waddr_d;
         done_q   <= done_d;
         inside_q <= inside_rectangle;
      end
   end

   sprite_ram_32x32 u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (waddr_q),
      .wdata_i (ram_wdata),
      .raddr_i (raddr),
      .rdata_o (ram_rdata)
   );

   // Outside the rectangle the pixel is forced transparent, aligned with the RAM latency.
   assign rgb_out         = inside_q ? ram_rdata : TRANSPARENT_ENCODING;
   assign drawing_request = (rgb_out != TRANSPARENT_ENCODING);
   assign busy            = (state_q != IDLE);
   assign done            = done_q;

endmodule

// File: tb/tb_sprite_bitmap_writer.sv
// tb/tb_sprite_bitmap_writer.sv - randomized scoreboard bench for sprite_bitmap_writer
// Exercises the clear path too when SPRITE_WRITER_CLEAR_EN is defined.
module tb_sprite_bitmap_writer;

   localparam logic [7:0] TR = 8'h1C;
   localparam int         NW = 1024;
`ifdef SPRITE_WRITER_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, load_start, s_valid, clear_start, inside_rectangle;
   logic [7:0]  s_data;
   logic [10:0] offset_x, offset_y;
   logic        s_ready, busy, done, drawing_request;
   logic [7:0]  rgb_out;

   always #5 clk = ~clk;

   sprite_bitmap_writer dut (
      .clk              (clk),
      .rst              (rst),
      .load_start       (load_start),
      .s_valid          (s_valid),
      .s_data           (s_data),
      .s_ready          (s_ready),
`ifdef SPRITE_WRITER_CLEAR_EN
      .clear_start      (clear_start),
`endif
      .busy             (busy),
      .done             (done),
      .offset_x         (offset_x),
      .offset_y         (offset_y),
      .inside_rectangle (inside_rectangle),
      .drawing_request  (drawing_request),
      .rgb_out          (rgb_out)
   );

   typedef struct {
      bit         care;
      logic [7:0] val;
   } rd_exp_t;

   rd_exp_t    exp_q[$];
   logic [7:0] m_mem [NW];
   bit         m_wr  [NW];
   int         m_mode = 0;      // 0 idle, 1 loading, 2 clearing
   int         m_addr = 0;
   bit         m_done = 1'b0;
   int         n_cmp = 0, n_fail = 0;
   int         dut_accepts = 0, dut_dones = 0, busy_cycles = 0;
   bit         acc_ok = 1'b0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // Reference model of the bitmap and operation progress, then output checks after each edge.
   always @(posedge clk) begin
      rd_exp_t e;
      if (acc_ok && s_valid && !rst) dut_accepts++;
      m_done = 1'b0;
      if (rst) begin
         m_mode = 0;
         m_addr = 0;
      end else begin
         case (m_mode)
            0: begin
               if (load_start) begin
                  m_mode = 1;
                  m_addr = 0;
               end else if (CLR_EN && clear_start) begin
                  m_mode = 2;
                  m_addr = 0;
               end
            end
            1: begin
               if (s_valid) begin
                  m_mem[m_addr] = s_data;
                  m_wr[m_addr]  = 1'b1;
                  if (m_addr == NW - 1) begin
                     m_mode = 0;
                     m_done = 1'b1;
                  end
                  m_addr++;
               end
            end
            default: begin
               m_mem[m_addr] = TR;
               m_wr[m_addr]  = 1'b1;
               if (m_addr == NW - 1) begin
                  m_mode = 0;
                  m_done = 1'b1;
               end
               m_addr++;
            end
         endcase
      end
      #1;
      acc_ok = s_ready;
      if (busy) busy_cycles++;
      if (done) dut_dones++;
      chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
      chk("s_ready", {31'd0, s_ready}, {31'd0, m_mode == 1});
      chk("done", {31'd0, done}, {31'd0, m_done});
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.care) begin
            chk("rgb_out", {24'd0, rgb_out}, {24'd0, e.val});
            chk("drawing_request", {31'd0, drawing_request}, {31'd0, e.val != TR});
         end
      end
   end

   task automatic tick(input bit ld, input bit cl, input bit v, input logic [7:0] d, input bit r,
                       input bit dir = 1'b0, input int dx = 0, input int dy = 0, input bit din = 1'b0);
      rd_exp_t e;
      int      a;
      load_start  = ld;
      clear_start = cl;
      s_valid     = v;
      s_data      = d;
      rst         = r;
      if (dir) begin
         offset_x         = dx[10:0];
         offset_y         = dy[10:0];
         inside_rectangle = din;
      end else begin
         offset_x         = 11'($urandom);
         offset_y         = 11'($urandom);
         inside_rectangle = ($urandom_range(0, 3) != 0);
      end
      a = int'({offset_y[4:0], offset_x[4:0]});
      if (r || !inside_rectangle) begin
         e.care = 1'b1;
         e.val  = TR;
      end else begin
         e.care = m_wr[a];
         e.val  = m_mem[a];
      end
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic rd(input int x, input int y, input bit ins);
      tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, x, y, ins);
   endtask

   initial begin
      int  acc0, dn0, bc0;
      bit  sent;
      rst = 1'b1; load_start = 1'b0; clear_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      offset_x = '0; offset_y = '0; inside_rectangle = 1'b0;
      @(negedge clk);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_s_ready", {31'd0, s_ready}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_rgb_out", {24'd0, rgb_out}, {24'd0, TR});
      chk("reset_drawing_request", {31'd0, drawing_request}, 32'd0);

      // Load 1: data equals address, valid held high.
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int c = 0; c < 3000 && m_mode != 0; c++) tick(1'b0, 1'b0, 1'b1, 8'(m_addr), 1'b0);
      chk("load1_idle_after_done", {31'd0, busy}, 32'd0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("load1_accepts", dut_accepts, 32'd1024);
      chk("load1_dones", dut_dones, 32'd1);

      rd(3, 1, 1'b1);
      chk("rd_x3_y1_rgb", {24'd0, rgb_out}, 32'h23);
      chk("rd_x3_y1_dr", {31'd0, drawing_request}, 32'd1);
      rd(28, 0, 1'b1);
      chk("rd_x28_y0_rgb", {24'd0, rgb_out}, 32'h1C);
      chk("rd_x28_y0_dr", {31'd0, drawing_request}, 32'd0);
      rd(3 + 32 * 5, 1 + 32 * 7, 1'b1);
      chk("rd_upper_bits_ignored", {24'd0, rgb_out}, 32'h23);
      rd(3, 1, 1'b0);
      chk("rd_outside_rgb", {24'd0, rgb_out}, 32'h1C);
      chk("rd_outside_dr", {31'd0, drawing_request}, 32'd0);
      repeat (50) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

      // Load 2: valid toggles, a second load_start at beat 500 must be ignored.
      acc0 = dut_accepts; dn0 = dut_dones; sent = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int c = 0; c < 5000 && m_mode != 0; c++) begin
         bit l;
         l = 1'b0;
         if (!sent && m_addr == 500) begin
            l = 1'b1;
            sent = 1'b1;
         end
         tick(l, 1'b0, c[0], 8'($urandom), 1'b0);
      end
      repeat (2) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("load2_accepts", dut_accepts - acc0, 32'd1024);
      chk("load2_dones", dut_dones - dn0, 32'd1);
      chk("load2_idle", {31'd0, busy}, 32'd0);
      repeat (60) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

      // Load 3: reset at beat 600 abandons the load.
      dn0 = dut_dones;
      tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int c = 0; c < 3000 && m_addr < 600; c++) tick(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
      tick(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_s_ready", {31'd0, s_ready}, 32'd0);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("abort_no_done", dut_dones - dn0, 32'd0);
      for (int a = 0; a < 640; a++) rd(a % 32, a / 32, 1'b1);

`ifdef SPRITE_WRITER_CLEAR_EN
      // Clear fills the bitmap with transparent, one word per cycle.
      dn0 = dut_dones; bc0 = busy_cycles;
      tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int c = 0; c < 3000 && m_mode != 0; c++) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("clear_busy_cycles", busy_cycles - bc0, 32'd1024);
      chk("clear_dones", dut_dones - dn0, 32'd1);
      for (int a = 0; a < NW; a++) rd(a % 32, a / 32, 1'b1);
      // Simultaneous start requests: load wins.
      tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("load_priority", {31'd0, s_ready}, 32'd1);
      for (int c = 0; c < 3000 && m_mode != 0; c++) tick(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0);
      repeat (40) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
`else
      bc0 = busy_cycles;
      chk("idle_no_busy", busy_cycles - bc0, 32'd0);
`endif

      repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
